rv_rr_arbiter: RTL and testbench
================================

RV_RR_ARBITER -- requirements
Module: rv_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning payload width per requester.
REQ-002 The block SHALL have parameter N, default 4, meaning requester count (N >= 2); IW = $clog2(N).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  N  per-requester valid, bit i = requester i.
REQ-006 The block SHALL have port in_ready  output  N  per-requester ready, bit i = requester i.
REQ-007 The block SHALL have port in_data  input  N*DW  packed payloads, requester i at bits [i*DW +: DW].
REQ-008 The block SHALL have port out_valid  output  1  output slot holds a valid beat.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-010 The block SHALL have port out_data  output  DW  payload of the held beat.
REQ-011 The block SHALL have port out_src  output  IW  requester index of the held beat.

Function
REQ-012 The block SHALL contain one output slot: full flag, DW data register, IW source register.
REQ-013 The slot SHALL be able to accept a beat (accept) when full=0, or when full=1 and out_ready=1.
REQ-014 The block SHALL keep a round-robin pointer ptr (IW bits) holding the last granted index.
REQ-015 Grant SHALL go to the first i with in_valid[i]=1, searching ptr+1, ptr+2, ... modulo N.
REQ-016 in_ready[i] SHALL be 1 only when i is the grant and accept=1; at most one in_ready bit high per cycle.
REQ-017 in_ready SHALL be combinational from in_valid, full, out_ready and ptr; it SHALL NOT depend on in_data.
REQ-018 A push is in_valid[g] & in_ready[g]; it SHALL load data and source from g, set full=1 and set ptr=g.
REQ-019 A pop is out_valid & out_ready; a pop without a push SHALL clear full, leaving data and source unchanged.
REQ-020 On a simultaneous push and pop the slot SHALL load the new beat, and full SHALL stay 1.
REQ-021 out_valid SHALL equal full; out_data and out_src SHALL be the registered slot contents.
REQ-022 Latency SHALL be 1 cycle from push edge to out_valid=1; sustained throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-023 With no in_valid bit set, ptr and the slot SHALL hold, except for a pop.
REQ-024 A requester dropping in_valid before grant SHALL lose nothing; grant is re-evaluated every cycle.
REQ-025 out_ready=1 while full=0 SHALL have no effect.
REQ-026 ptr SHALL wrap from N-1 to 0.

Reset
REQ-027 rst_n=0 SHALL asynchronously force full=0, data register=0, source register=0, ptr=N-1.
REQ-028 During and after reset, outputs SHALL be out_valid=0, out_data=0, out_src=0, and the first grant SHALL go to requester 0.
REQ-029 Reset mid-transfer SHALL discard the held beat and SHALL NOT produce a pop or push.

Configuration
REQ-030 With macro RV_ARB_PRIO0_EN defined, requester 0 SHALL win whenever in_valid[0]=1; the other requesters SHALL be granted round-robin among 1..N-1 only when in_valid[0]=0.
REQ-031 With RV_ARB_PRIO0_EN defined, a grant to requester 0 SHALL NOT update ptr.
REQ-032 With RV_ARB_PRIO0_EN undefined, all N requesters SHALL be pure round-robin per REQ-015.

Verification
REQ-033 Scenario: after reset, in_valid=4'b1111 and out_ready=1 held -> out_src sequence SHALL be 0,1,2,3,0, one beat per cycle after 1-cycle latency.
REQ-034 Scenario: in_valid=4'b0100, in_data[2]=32'hCAFE0002, out_ready=0 -> SHALL push once; then out_valid=1, out_data=32'hCAFE0002, out_src=2, in_ready=0 until out_ready=1.
REQ-035 Scenario: full=1, out_ready=1, in_valid[1]=1 with data 32'h11 in the same cycle -> SHALL pop the old beat and push the new one; the next cycle SHALL show out_valid=1, out_data=32'h11.
REQ-036 Scenario: ptr=3, in_valid=4'b1001 -> SHALL grant requester 0, then requester 3 (wrap).
REQ-037 Scenario: rst_n pulsed low asynchronously while full=1 -> out_valid SHALL go 0 immediately, and the first grant after release SHALL go to requester 0.
REQ-038 Scenario (RV_ARB_PRIO0_EN defined): in_valid=4'b0111, out_ready=1 -> SHALL grant 0 every cycle; after in_valid[0] drops, grants SHALL go 1,2,1,2.

Source files
------------

// File: rtl/rv_rr_arbiter.sv
// Round-robin N:1 ready/valid arbiter with a single registered output slot.
// Optional build macro RV_ARB_PRIO0_EN: requester 0 becomes strict-priority; the others stay round-robin.
module rv_rr_arbiter #(
    parameter int DW = 32,
    parameter int N  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*DW-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_src
);

    localparam int IW = $clog2(N);

    logic          full;
    logic [DW-1:0] data_q;
    logic [IW-1:0] src_q;
    logic [IW-1:0] ptr;

    logic          found;
    logic [IW-1:0] grant;
    logic [IW-1:0] idx;
    logic [DW-1:0] grant_data;
    logic          accept;
    logic          push;
    logic          pop;

    assign accept = ~full | out_ready;
    assign push   = found & accept;
    assign pop    = full & out_ready;

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
`ifdef RV_ARB_PRIO0_EN
        if (in_valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IW'(i)) begin
                grant_data = in_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (push) begin
            in_ready[grant] = 1'b1;
        end
    end

    // A push always wins over a pop: the slot is refilled and stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
            ptr    <= IW'(N - 1);
        end else begin
            if (push) begin
                full   <= 1'b1;
                data_q <= grant_data;
                src_q  <= grant;
`ifdef RV_ARB_PRIO0_EN
                if (grant != '0) begin
                    ptr <= grant;
                end
`else
                ptr <= grant;
`endif
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

    assign out_valid = full;
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Directed, table-driven bench for rv_rr_arbiter (N=4, DW=32), plus hand-written reset sequences.
module tb_rv_rr_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [3:0]  valid;
        logic        ordy;
        logic [31:0] tag;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t vecs[$];

    rv_rr_arbiter #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    // Lane i carries tag + i.
    function automatic logic [N*DW-1:0] lanes(input logic [31:0] tag);
        return {tag + 32'd3, tag + 32'd2, tag + 32'd1, tag};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic r, input logic [31:0] t,
                       input logic [3:0] er, input logic eo, input logic [31:0] ed,
                       input logic [1:0] es);
        vec_t x;
        x.valid = v; x.ordy = r; x.tag = t;
        x.exp_rdy = er; x.exp_ov = eo; x.exp_data = ed; x.exp_src = es;
        vecs.push_back(x);
    endtask

    initial begin
`ifdef RV_ARB_PRIO0_EN
        // Requester 0 dominates, then 1 and 2 alternate.
        add(4'b0111, 1, 32'h70, 4'b0001, 1, 32'h70, 2'd0);
        add(4'b0111, 1, 32'h70, 4'b0001, 1, 32'h70, 2'd0);
        add(4'b0111, 1, 32'h70, 4'b0001, 1, 32'h70, 2'd0);
        add(4'b0110, 1, 32'h70, 4'b0010, 1, 32'h71, 2'd1);
        add(4'b0110, 1, 32'h70, 4'b0100, 1, 32'h72, 2'd2);
        add(4'b0110, 1, 32'h70, 4'b0010, 1, 32'h71, 2'd1);
        add(4'b0110, 1, 32'h70, 4'b0100, 1, 32'h72, 2'd2);
        add(4'b0000, 1, 32'h70, 4'b0000, 0, 32'h72, 2'd2);
`else
        // All requesting: 0,1,2,3,0 at one beat per cycle, then drain.
        add(4'b1111, 1, 32'hA0, 4'b0001, 1, 32'hA0, 2'd0);
        add(4'b1111, 1, 32'hA0, 4'b0010, 1, 32'hA1, 2'd1);
        add(4'b1111, 1, 32'hA0, 4'b0100, 1, 32'hA2, 2'd2);
        add(4'b1111, 1, 32'hA0, 4'b1000, 1, 32'hA3, 2'd3);
        add(4'b1111, 1, 32'hA0, 4'b0001, 1, 32'hA0, 2'd0);
        add(4'b0000, 1, 32'hA0, 4'b0000, 0, 32'hA0, 2'd0);
        // Single push under backpressure, held until the consumer is ready.
        add(4'b0100, 0, 32'hCAFE0000, 4'b0100, 1, 32'hCAFE0002, 2'd2);
        add(4'b0100, 0, 32'hCAFE0000, 4'b0000, 1, 32'hCAFE0002, 2'd2);
        add(4'b0100, 0, 32'hCAFE0000, 4'b0000, 1, 32'hCAFE0002, 2'd2);
        add(4'b0000, 1, 32'hCAFE0000, 4'b0000, 0, 32'hCAFE0002, 2'd2);
        add(4'b0000, 1, 32'hCAFE0000, 4'b0000, 0, 32'hCAFE0002, 2'd2);
        // Simultaneous pop and push.
        add(4'b0001, 0, 32'h50, 4'b0001, 1, 32'h50, 2'd0);
        add(4'b0010, 1, 32'h10, 4'b0010, 1, 32'h11, 2'd1);
        add(4'b0000, 1, 32'h10, 4'b0000, 0, 32'h11, 2'd1);
        // Pointer at 3: requester 0 first, then 3 after the wrap.
        add(4'b1000, 1, 32'h30, 4'b1000, 1, 32'h33, 2'd3);
        add(4'b1001, 1, 32'h40, 4'b0001, 1, 32'h40, 2'd0);
        add(4'b1001, 1, 32'h40, 4'b1000, 1, 32'h43, 2'd3);
        // Hold without pop, a request that withdraws while blocked, then drain.
        add(4'b0000, 0, 32'h40, 4'b0000, 1, 32'h43, 2'd3);
        add(4'b0100, 0, 32'h60, 4'b0000, 1, 32'h43, 2'd3);
        add(4'b0000, 1, 32'h60, 4'b0000, 0, 32'h43, 2'd3);
`endif

        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = lanes(32'h0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_src", 32'(out_src), 32'd0);
        check("reset_first_grant", 32'(in_ready), 32'b0001);

        @(negedge clk);
        in_valid = 4'b0000;
        rst_n    = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            in_data   = lanes(vecs[i].tag);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("v%0d_out_src", i), 32'(out_src), 32'(vecs[i].exp_src));
        end

        // Fill the slot, then reset asynchronously between clock edges.
        @(negedge clk);
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        in_data   = lanes(32'h90);
        @(posedge clk);
        #1;
        check("pre_reset_full", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_out_data", out_data, 32'd0);
        check("async_reset_out_src", 32'(out_src), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = lanes(32'hB0);
        #1;
        check("post_reset_grant", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("post_reset_out_valid", 32'(out_valid), 32'd1);
        check("post_reset_out_src", 32'(out_src), 32'd0);
        check("post_reset_out_data", out_data, 32'hB0);

        @(negedge clk);
        in_valid = 4'b0000;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
